// File: rtl/bullet_field.sv
// ---------------------------------------------------------------------------
// bullet_field
//
// Bullet table for the battle arena. Holds 8 bullets (x, y, w, h, colour,
// direction, active flag), advances every bullet by SPEED pixels on each
// game-tick step while run is high, wraps bullets that would cross the far
// arena bound back to the near bound, and retires the bullet selected by
// index2 when a collision is reported. Two independent combinational read
// ports expose the table to the renderer and to the damage logic.
//
// Ports:
//   clk       in   system clock
//   reset_n   in   synchronous active-low reset (restores the full table)
//   tick      in   slow game-tick level (asynchronous, synchronised here)
//   run       in   1 = movement enabled, 0 = positions frozen
//   collide   in   bullet[index2] overlaps the player this cycle
//   index     in   render-port bullet select
//   pos       out  render port {x, y}
//   size      out  render port {w, h}
//   color     out  render port colour code
//   render    out  render port active flag
//   index2    in   damage-port bullet select
//   pos2/size2/color2/render2  out  same fields for bullet[index2]
//
// Build option:
//   BULLET_FIELD_BOUNCE_EN  when defined, bullets reverse direction at the
//                           arena bounds (clamped to the bound) instead of
//                           wrapping; each bounce reactivates the bullet.
// ---------------------------------------------------------------------------
module bullet_field #(
   parameter logic [7:0] X_MIN    = 8'd40,
   parameter logic [7:0] X_MAX    = 8'd215,
   parameter logic [7:0] Y_MIN    = 8'd40,
   parameter logic [7:0] Y_MAX    = 8'd215,
   parameter logic [7:0] SPEED    = 8'd2,
   parameter logic [7:0] BULLET_W = 8'd8,
   parameter logic [7:0] BULLET_H = 8'd8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        tick,
   input  logic        run,
   input  logic        collide,
   input  logic [2:0]  index,
   output logic [15:0] pos,
   output logic [15:0] size,
   output logic [2:0]  color,
   output logic        render,
   input  logic [2:0]  index2,
   output logic [15:0] pos2,
   output logic [15:0] size2,
   output logic [2:0]  color2,
   output logic        render2
);

   localparam int NUM_BULLETS = 8;

   // ------------------------------------------------------------------
   // Tick synchroniser and rising-edge detector
   // ------------------------------------------------------------------
   logic tick_s1_q;
   logic tick_s2_q;
   logic tick_s3_q;
   logic step;
   logic move;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tick_s1_q <= 1'b0;
         tick_s2_q <= 1'b0;
         tick_s3_q <= 1'b0;
      end else begin
         tick_s1_q <= tick;
         tick_s2_q <= tick_s1_q;
         tick_s3_q <= tick_s2_q;
      end
   end

   // One-cycle pulse per rising tick; s1 is the metastability stage and is
   // never used directly.
   assign step = tick_s2_q & ~tick_s3_q;
   // A step seen while frozen is simply dropped.
   assign move = step & run;

   // ------------------------------------------------------------------
   // Table views collected from the per-bullet slices for the read ports
   // ------------------------------------------------------------------
   logic [NUM_BULLETS-1:0][7:0] x_tab;
   logic [NUM_BULLETS-1:0][7:0] y_tab;
   logic [NUM_BULLETS-1:0][7:0] w_tab;
   logic [NUM_BULLETS-1:0][7:0] h_tab;
   logic [NUM_BULLETS-1:0][2:0] color_tab;
   logic [NUM_BULLETS-1:0]      active_tab;

   // ------------------------------------------------------------------
   // Per-bullet state and next-state logic
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_BULLETS; gi++) begin : g_bullet
         localparam logic [7:0] X_RST     = 8'(X_MIN + 20 * gi);
         localparam logic [7:0] Y_RST     = 8'(Y_MIN + 20 * gi);
         localparam logic [2:0] COLOR_RST = 3'(gi % 4);
         localparam logic       DIR_RST   = ((gi % 2) == 1);

         logic [7:0] x_q;
         logic [7:0] x_d;
         logic [7:0] y_q;
         logic [7:0] y_d;
         logic [7:0] w_q;
         logic [7:0] h_q;
         logic [2:0] color_q;
         logic       dir_q;
         logic       active_q;
         logic       active_d;
`ifdef BULLET_FIELD_BOUNCE_EN
         logic       neg_q;     // 1 = moving towards the near bound
         logic       neg_d;
`endif

         // Only the coordinate along dir moves, so the bound logic works on
         // a single selected axis.
         logic [7:0] coord;
         logic [7:0] extent;
         logic [7:0] lo_bound;
         logic [7:0] hi_bound;
         logic [7:0] coord_next;
         logic [9:0] far_edge;
         logic       bound_hit;

         always_comb begin
            coord    = dir_q ? y_q : x_q;
            extent   = dir_q ? h_q : w_q;
            lo_bound = dir_q ? Y_MIN : X_MIN;
            hi_bound = dir_q ? Y_MAX : X_MAX;

            // Last pixel the bullet would cover after the step; kept wide so
            // the comparison never sees an 8-bit wrap-around.
            far_edge = {2'b00, coord} + {2'b00, SPEED} + {2'b00, extent} - 10'd1;

`ifdef BULLET_FIELD_BOUNCE_EN
            neg_d = neg_q;
            if (neg_q) begin
               bound_hit  = {2'b00, coord} < ({2'b00, lo_bound} + {2'b00, SPEED});
               coord_next = bound_hit ? lo_bound : (coord - SPEED);
            end else begin
               bound_hit  = far_edge > {2'b00, hi_bound};
               coord_next = bound_hit ? 8'(hi_bound - extent + 8'd1) : (coord + SPEED);
            end
`else
            bound_hit  = far_edge > {2'b00, hi_bound};
            coord_next = bound_hit ? lo_bound : (coord + SPEED);
`endif

            x_d      = x_q;
            y_d      = y_q;
            active_d = active_q;

            // Collision retires the bullet; ordered before the move so a
            // wrap/bounce on the same edge wins and keeps it active.
            if (collide && (index2 == 3'(gi))) begin
               active_d = 1'b0;
            end

            if (move) begin
               if (dir_q) begin
                  y_d = coord_next;
               end else begin
                  x_d = coord_next;
               end
               if (bound_hit) begin
                  active_d = 1'b1;
`ifdef BULLET_FIELD_BOUNCE_EN
                  neg_d = ~neg_q;
`endif
               end
            end
         end

         // w, h, colour and dir are loaded at reset only and then held.
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               x_q      <= X_RST;
               y_q      <= Y_RST;
               w_q      <= BULLET_W;
               h_q      <= BULLET_H;
               color_q  <= COLOR_RST;
               dir_q    <= DIR_RST;
               active_q <= 1'b1;
`ifdef BULLET_FIELD_BOUNCE_EN
               neg_q    <= 1'b0;
`endif
            end else begin
               x_q      <= x_d;
               y_q      <= y_d;
               active_q <= active_d;
`ifdef BULLET_FIELD_BOUNCE_EN
               neg_q    <= neg_d;
`endif
            end
         end

         assign x_tab[gi]      = x_q;
         assign y_tab[gi]      = y_q;
         assign w_tab[gi]      = w_q;
         assign h_tab[gi]      = h_q;
         assign color_tab[gi]  = color_q;
         assign active_tab[gi] = active_q;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Read ports: zero-latency muxes straight off the table
   // ------------------------------------------------------------------
   assign pos    = {x_tab[index], y_tab[index]};
   assign size   = {w_tab[index], h_tab[index]};
   assign color  = color_tab[index];
   assign render = active_tab[index];

   assign pos2    = {x_tab[index2], y_tab[index2]};
   assign size2   = {w_tab[index2], h_tab[index2]};
   assign color2  = color_tab[index2];
   assign render2 = active_tab[index2];

endmodule

// File: tb/tb_bullet_field.sv
// ---------------------------------------------------------------------------
// tb_bullet_field
//
// Self-checking bench for bullet_field: directed scenarios (reset table,
// single tick, frozen ticks, wrap, collision, wrap-vs-collision, mid-run
// reset, lost pending step) followed by randomized stimulus, all compared
// against a behavioural model of the bullet table.
// ---------------------------------------------------------------------------
module tb_bullet_field;

   localparam int XMIN = 40;
   localparam int XMAX = 215;
   localparam int YMIN = 40;
   localparam int YMAX = 215;
   localparam int SPD  = 2;
   localparam int BW   = 8;
   localparam int BH   = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        tick;
   logic        run;
   logic        collide;
   logic [2:0]  index;
   logic [2:0]  index2;
   logic [15:0] pos;
   logic [15:0] size;
   logic [2:0]  color;
   logic        render;
   logic [15:0] pos2;
   logic [15:0] size2;
   logic [2:0]  color2;
   logic        render2;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   int mx [8];
   int my [8];
   bit mact [8];
   bit ms1, ms2, ms3;

   always #25 clk = ~clk;

   bullet_field dut (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (tick),
      .run     (run),
      .collide (collide),
      .index   (index),
      .pos     (pos),
      .size    (size),
      .color   (color),
      .render  (render),
      .index2  (index2),
      .pos2    (pos2),
      .size2   (size2),
      .color2  (color2),
      .render2 (render2)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         mx[i]   = XMIN + 20 * i;
         my[i]   = YMIN + 20 * i;
         mact[i] = 1'b1;
      end
      ms1 = 1'b0;
      ms2 = 1'b0;
      ms3 = 1'b0;
   endtask

   // Applies one clock edge worth of the table rules to the model.
   task automatic model_clock();
      bit wrapped [8];
      bit stp;
      if (!reset_n) begin
         model_reset();
      end else begin
         stp = ms2 && !ms3;
         for (int i = 0; i < 8; i++) wrapped[i] = 1'b0;
         if (stp && run) begin
            for (int i = 0; i < 8; i++) begin
               if (i % 2 == 0) begin
                  if (mx[i] + SPD + BW - 1 > XMAX) begin
                     mx[i] = XMIN;
                     wrapped[i] = 1'b1;
                  end else begin
                     mx[i] = mx[i] + SPD;
                  end
               end else begin
                  if (my[i] + SPD + BH - 1 > YMAX) begin
                     my[i] = YMIN;
                     wrapped[i] = 1'b1;
                  end else begin
                     my[i] = my[i] + SPD;
                  end
               end
            end
         end
         if (collide) mact[index2] = 1'b0;
         for (int i = 0; i < 8; i++) if (wrapped[i]) mact[i] = 1'b1;
         ms3 = ms2;
         ms2 = ms1;
         ms1 = tick;
      end
   endtask

   function automatic logic [15:0] mpos(input int i);
      logic [7:0] xv;
      logic [7:0] yv;
      xv = 8'(mx[i]);
      yv = 8'(my[i]);
      return {xv, yv};
   endfunction

   // One clock: edge, model update, land on the next falling edge.
   task automatic cyc();
      @(posedge clk);
      model_clock();
      @(negedge clk);
   endtask

   task automatic check_ports(input string tag);
      chk({tag, ".pos"},     32'(pos),     32'(mpos(int'(index))));
      chk({tag, ".size"},    32'(size),    32'h0808);
      chk({tag, ".color"},   32'(color),   {30'b0, index[1:0]});
      chk({tag, ".render"},  32'(render),  32'(mact[index]));
      chk({tag, ".pos2"},    32'(pos2),    32'(mpos(int'(index2))));
      chk({tag, ".size2"},   32'(size2),   32'h0808);
      chk({tag, ".color2"},  32'(color2),  {30'b0, index2[1:0]});
      chk({tag, ".render2"}, 32'(render2), 32'(mact[index2]));
   endtask

   // Sweeps the whole table on both ports; call only with collide low.
   task automatic check_table(input string tag);
      for (int i = 0; i < 8; i++) begin
         index  = 3'(i);
         index2 = 3'(7 - i);
         #1;
         check_ports($sformatf("%s.b%0d", tag, i));
      end
   endtask

   task automatic check_const(input string tag, input int i, input logic [15:0] exp_pos,
                              input logic exp_render);
      index = 3'(i);
      #1;
      chk({tag, ".pos"},    32'(pos),    32'(exp_pos));
      chk({tag, ".render"}, 32'(render), 32'(exp_render));
   endtask

   // One full tick pulse; the table step lands on the 3rd edge. When
   // coll_idx >= 0, collide is asserted on exactly that step edge.
   task automatic do_tick(input int coll_idx);
      tick = 1'b1;
      cyc();
      cyc();
      if (coll_idx >= 0) begin
         collide = 1'b1;
         index2  = 3'(coll_idx);
      end
      cyc();
      collide = 1'b0;
      tick    = 1'b0;
      cyc();
      cyc();
      cyc();
   endtask

   initial begin
      reset_n = 1'b0;
      tick    = 1'b0;
      run     = 1'b0;
      collide = 1'b0;
      index   = 3'd0;
      index2  = 3'd0;

      // ---------------- reset table ----------------
      cyc();
      reset_n = 1'b1;
      $display("txn reset");
      index = 3'd3;
      #1;
      chk("rst.b3.pos",    32'(pos),    32'h6464);
      chk("rst.b3.size",   32'(size),   32'h0808);
      chk("rst.b3.color",  32'(color),  32'd3);
      chk("rst.b3.render", 32'(render), 32'd1);
      check_const("rst.b7", 7, 16'hB4B4, 1'b1);
      check_table("rst");

      // ---------------- frozen: ticks discarded ----------------
      run = 1'b0;
      for (int t = 0; t < 5; t++) begin
         do_tick(-1);
         $display("txn tick run=0 n=%0d", t);
      end
      check_const("frz.b0", 0, 16'h2828, 1'b1);
      check_const("frz.b7", 7, 16'hB4B4, 1'b1);
      check_table("frz");

      // ---------------- single tick, edge by edge ----------------
      run  = 1'b1;
      tick = 1'b1;
      cyc();
      check_const("tk.e1.b0", 0, 16'h2828, 1'b1);
      cyc();
      check_const("tk.e2.b0", 0, 16'h2828, 1'b1);
      cyc();
      check_const("tk.e3.b0", 0, 16'h2A28, 1'b1);
      check_const("tk.e3.b1", 1, 16'h3C3E, 1'b1);
      for (int e = 0; e < 4; e++) cyc();
      check_const("tk.hold.b0", 0, 16'h2A28, 1'b1);
      tick = 1'b0;
      for (int e = 0; e < 3; e++) cyc();
      $display("txn tick run=1 single");
      check_table("tk");

      // ---------------- wrap and collision ----------------
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      collide = 1'b1;
      index2  = 3'd2;
      cyc();
      collide = 1'b0;
      index   = 3'd2;
      index2  = 3'd2;
      #1;
      $display("txn collide idx=2");
      chk("coll2.render",  32'(render),  32'd0);
      chk("coll2.render2", 32'(render2), 32'd0);
      for (int t = 1; t <= 65; t++) begin
         do_tick((t == 35) ? 5 : -1);
         $display("txn tick run=1 n=%0d%s", t, (t == 35) ? " collide idx=5" : "");
         if (t == 24) check_const("wrap.b6.pre",  6, 16'hD0A0, 1'b1);
         if (t == 25) check_const("wrap.b6.post", 6, 16'h28A0, 1'b1);
         if (t == 35) check_const("wrapcoll.b5",  5, 16'h8C28, 1'b1);
         if (t == 64) check_const("coll2.pre",    2, 16'hD050, 1'b0);
         if (t == 65) check_const("coll2.post",   2, 16'h2850, 1'b1);
         check_table($sformatf("wr%0d", t));
      end

      // ---------------- mid-operation reset ----------------
      for (int t = 0; t < 10; t++) do_tick(-1);
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      $display("txn reset mid-run");
      check_const("mrst.b0", 0, 16'h2828, 1'b1);
      check_const("mrst.b7", 7, 16'hB4B4, 1'b1);
      check_table("mrst");

      // Step pending at the reset edge is lost
      tick = 1'b1;
      cyc();
      cyc();
      tick    = 1'b0;
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      for (int e = 0; e < 4; e++) cyc();
      $display("txn reset with pending step");
      check_const("lost.b0", 0, 16'h2828, 1'b1);
      check_const("lost.b1", 1, 16'h3C3C, 1'b1);

      // ---------------- randomized ----------------
      for (int c = 0; c < 3000; c++) begin
         reset_n = ($urandom_range(0, 249) != 0);
         if ($urandom_range(0, 3) == 0) tick = ~tick;
         run     = ($urandom_range(0, 3) != 0);
         collide = ($urandom_range(0, 9) == 0);
         index   = 3'($urandom_range(0, 7));
         index2  = 3'($urandom_range(0, 7));
         #1;
         $display("txn rnd=%0d rst_n=%0b tick=%0b run=%0b coll=%0b i=%0d i2=%0d",
                  c, reset_n, tick, run, collide, index, index2);
         check_ports($sformatf("rnd%0d", c));
         cyc();
      end
      collide = 1'b0;
      reset_n = 1'b1;
      check_table("final");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
